// File: rtl/reset_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// rst_seq_pkg
//   Shared types and sizing helpers for the reset sequencer.
//   - rst_seq_state_t : sequencer FSM state encoding
//   - idx_width()     : width of a stage index (at least one bit)
//   - cnt_width()     : width of the shared hold/gap/timeout counter
// -----------------------------------------------------------------------------
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,  // all stage resets held
    RELEASE = 2'd1,  // stage idx released, waiting for its ready or timeout
    GAP     = 2'd2,  // spacing before the next stage is released
    DONE    = 2'd3   // every stage released
  } rst_seq_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Largest terminal value is max-1, so clog2(max) bits always hold it.
  function automatic int cnt_width(input int hold, input int gap, input int tmo);
    int m;
    m = max3(hold, gap, tmo);
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

  function automatic int idx_width(input int num_stages);
    return (num_stages <= 1) ? 1 : $clog2(num_stages);
  endfunction

endpackage

// File: rtl/reset_sequencer_timer.sv
// -----------------------------------------------------------------------------
// rst_seq_timer
//   Clear/enable up-counter with a terminal-count compare.
//   Ports:
//     clk      : system clock, rising edge
//     i_clr    : synchronous clear (highest priority)
//     i_en     : count enable
//     i_tc_val : terminal value to compare against
//     o_tc     : high while the count equals i_tc_val
// -----------------------------------------------------------------------------
module rst_seq_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_tc_val,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values of its sources, independent of statement order.
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_tc = (r_cnt == i_tc_val);

endmodule

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//   Drives ordered, stretched active-high resets to NUM_STAGES domains. All
//   stage resets are held for HOLD_CYCLES, then stages are released in index
//   order; each release waits for that stage's ready (or TIMEOUT_CYCLES) and
//   then GAP_CYCLES before the next stage goes.
//   Ports:
//     clk         : system clock, rising edge
//     reset       : synchronous active-high block reset, highest priority
//     sw_rst_req  : one-edge request to restart the whole sequence
//     stage_ready : per-stage release acknowledge, synchronous to clk
//     rst_out     : per-stage active-high reset (registered)
//     seq_busy    : sequence in progress (registered)
//     seq_done    : all stages released (registered)
//     timeout_err : sticky, some stage timed out (registered)
//     err_stage   : index of the most recent timed-out stage (registered)
//   Parameters must all be >= 1.
// -----------------------------------------------------------------------------
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES     = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int GAP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                sw_rst_req,
  input  logic [NUM_STAGES-1:0]               stage_ready,
  output logic [NUM_STAGES-1:0]               rst_out,
  output logic                                seq_busy,
  output logic                                seq_done,
  output logic                                timeout_err,
  output logic [idx_width(NUM_STAGES)-1:0]    err_stage
);

  localparam int IDX_W = idx_width(NUM_STAGES);
  localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);

  localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TC   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_TC   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  rst_seq_state_t        r_state,       w_state_nxt;
  logic [IDX_W-1:0]      r_idx,         w_idx_nxt;
  logic [NUM_STAGES-1:0] r_rst_out,     w_rst_out_nxt;
  logic                  r_seq_busy,    w_seq_busy_nxt;
  logic                  r_seq_done,    w_seq_done_nxt;
  logic                  r_timeout_err, w_timeout_err_nxt;
  logic [IDX_W-1:0]      r_err_stage,   w_err_stage_nxt;

  logic                  w_cnt_clr;
  logic                  w_cnt_en;
  logic                  w_tc;
  logic [CNT_W-1:0]      w_tc_val;
  logic                  w_ready;

  // One-hot mask for a stage index; out-of-range indices give an empty mask,
  // which keeps indexing safe for any NUM_STAGES including 1.
  function automatic logic [NUM_STAGES-1:0] stage_bit(input int idx);
    logic [NUM_STAGES-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (i == idx) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Only the ready bit of the stage currently being released matters.
  assign w_ready = |(stage_ready & stage_bit(int'(r_idx)));

  // --------------------------------------------------------------------------
  // Shared counter: cleared on any restart and on every state change.
  // --------------------------------------------------------------------------
  assign w_cnt_clr = reset | sw_rst_req | (w_state_nxt != r_state);
  assign w_cnt_en  = (r_state != DONE);

  rst_seq_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .i_clr    (w_cnt_clr),
    .i_en     (w_cnt_en),
    .i_tc_val (w_tc_val),
    .o_tc     (w_tc)
  );

  // --------------------------------------------------------------------------
  // Next-state and next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    w_state_nxt       = r_state;
    w_idx_nxt         = r_idx;
    w_rst_out_nxt     = r_rst_out;
    w_seq_busy_nxt    = r_seq_busy;
    w_seq_done_nxt    = r_seq_done;
    w_timeout_err_nxt = r_timeout_err;
    w_err_stage_nxt   = r_err_stage;
    w_tc_val          = HOLD_TC;

    unique case (r_state)
      ASSERT:  w_tc_val = HOLD_TC;
      RELEASE: w_tc_val = TMO_TC;
      GAP:     w_tc_val = GAP_TC;
      default: w_tc_val = HOLD_TC;
    endcase

    if (sw_rst_req) begin
      // Software restart outranks ready and terminal-count events this edge.
      w_state_nxt       = ASSERT;
      w_idx_nxt         = '0;
      w_rst_out_nxt     = '1;
      w_seq_busy_nxt    = 1'b1;
      w_seq_done_nxt    = 1'b0;
      w_timeout_err_nxt = 1'b0;
      w_err_stage_nxt   = '0;
    end else begin
      unique case (r_state)
        ASSERT: begin
          w_rst_out_nxt  = '1;
          w_seq_busy_nxt = 1'b1;
          if (w_tc) begin
            w_state_nxt   = RELEASE;
            w_rst_out_nxt = ~stage_bit(0);
          end
        end

        RELEASE: begin
          if (w_ready || w_tc) begin
            if (!w_ready) begin
              w_timeout_err_nxt = 1'b1;
              w_err_stage_nxt   = r_idx;
            end
            if (r_idx == LAST_IDX) begin
              w_state_nxt    = DONE;
              w_rst_out_nxt  = '0;
              w_seq_busy_nxt = 1'b0;
              w_seq_done_nxt = 1'b1;
            end else begin
              w_state_nxt = GAP;
            end
          end
        end

        GAP: begin
          if (w_tc) begin
            w_state_nxt   = RELEASE;
            w_idx_nxt     = r_idx + IDX_W'(1);
            w_rst_out_nxt = r_rst_out & ~stage_bit(int'(r_idx) + 1);
          end
        end

        DONE: begin
          w_rst_out_nxt  = '0;
          w_seq_busy_nxt = 1'b0;
          w_seq_done_nxt = 1'b1;
        end

        default: begin
          w_state_nxt    = ASSERT;
          w_idx_nxt      = '0;
          w_rst_out_nxt  = '1;
          w_seq_busy_nxt = 1'b1;
          w_seq_done_nxt = 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ASSERT;
      r_idx         <= '0;
      r_rst_out     <= '1;
      r_seq_busy    <= 1'b1;
      r_seq_done    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_err_stage   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_rst_out     <= w_rst_out_nxt;
      r_seq_busy    <= w_seq_busy_nxt;
      r_seq_done    <= w_seq_done_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      r_err_stage   <= w_err_stage_nxt;
    end
  end

  assign rst_out     = r_rst_out;
  assign seq_busy    = r_seq_busy;
  assign seq_done    = r_seq_done;
  assign timeout_err = r_timeout_err;
  assign err_stage   = r_err_stage;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//   Table-driven bench for reset_sequencer (defaults: 4 stages, hold 16,
//   gap 8, timeout 64) plus hand-written multi-cycle sequences and a second
//   instance with one stage and a one-cycle hold.
//   Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic       reset = 1'b1;
  logic       sw_rst_req = 1'b0;
  logic [3:0] stage_ready = 4'h0;
  logic [3:0] rst_out;
  logic       seq_busy;
  logic       seq_done;
  logic       timeout_err;
  logic [1:0] err_stage;

  reset_sequencer u_dut (
    .clk         (clk),
    .reset       (reset),
    .sw_rst_req  (sw_rst_req),
    .stage_ready (stage_ready),
    .rst_out     (rst_out),
    .seq_busy    (seq_busy),
    .seq_done    (seq_done),
    .timeout_err (timeout_err),
    .err_stage   (err_stage)
  );

  // Single-stage instance, one-cycle hold, ready tied high
  logic       reset1 = 1'b1;
  logic       sw1 = 1'b0;
  logic [0:0] ready1 = 1'b1;
  logic [0:0] rst_out1;
  logic       busy1;
  logic       done1;
  logic       terr1;
  logic [0:0] estage1;

  reset_sequencer #(
    .NUM_STAGES  (1),
    .HOLD_CYCLES (1)
  ) u_dut1 (
    .clk         (clk),
    .reset       (reset1),
    .sw_rst_req  (sw1),
    .stage_ready (ready1),
    .rst_out     (rst_out1),
    .seq_busy    (busy1),
    .seq_done    (done1),
    .timeout_err (terr1),
    .err_stage   (estage1)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int unsigned cycles;
    logic        rst;
    logic        sw;
    logic [3:0]  ready;
    logic [3:0]  exp_rst;
    logic        exp_busy;
    logic        exp_done;
    logic        exp_terr;
    logic [1:0]  exp_estage;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] e_rst, input logic e_busy,
                           input logic e_done, input logic e_terr, input logic [1:0] e_est);
    check({tag, ".rst_out"},     32'(rst_out),     32'(e_rst));
    check({tag, ".seq_busy"},    32'(seq_busy),    32'(e_busy));
    check({tag, ".seq_done"},    32'(seq_done),    32'(e_done));
    check({tag, ".timeout_err"}, 32'(timeout_err), 32'(e_terr));
    check({tag, ".err_stage"},   32'(err_stage),   32'(e_est));
  endtask

  // Advance n rising edges, then settle on the following falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  function automatic void add(input int unsigned cyc, input logic r, input logic s,
                              input logic [3:0] rdy, input logic [3:0] e_rst,
                              input logic e_busy, input logic e_done,
                              input logic e_terr, input logic [1:0] e_est);
    vec_t v;
    v.cycles = cyc;  v.rst = r;  v.sw = s;  v.ready = rdy;
    v.exp_rst = e_rst;  v.exp_busy = e_busy;  v.exp_done = e_done;
    v.exp_terr = e_terr;  v.exp_estage = e_est;
    vecs.push_back(v);
  endfunction

  // Nominal timeline from the first edge after a restart; ready[i] is first
  // sampled high two edges after rst_out[i] falls. Edge numbers in comments.
  function automatic void add_nominal();
    add(15, 0, 0, 4'b0000, 4'hF, 1, 0, 0, 0);  // 15: still held
    add( 1, 0, 0, 4'b0000, 4'hE, 1, 0, 0, 0);  // 16: stage 0 released
    add( 1, 0, 0, 4'b0000, 4'hE, 1, 0, 0, 0);  // 17
    add( 1, 0, 0, 4'b0001, 4'hE, 1, 0, 0, 0);  // 18: ready0 -> GAP
    add( 7, 0, 0, 4'b0001, 4'hE, 1, 0, 0, 0);  // 25
    add( 1, 0, 0, 4'b0001, 4'hC, 1, 0, 0, 0);  // 26: stage 1 released
    add( 1, 0, 0, 4'b0001, 4'hC, 1, 0, 0, 0);  // 27
    add( 1, 0, 0, 4'b0011, 4'hC, 1, 0, 0, 0);  // 28
    add( 7, 0, 0, 4'b0011, 4'hC, 1, 0, 0, 0);  // 35
    add( 1, 0, 0, 4'b0011, 4'h8, 1, 0, 0, 0);  // 36: stage 2 released
    add( 1, 0, 0, 4'b0011, 4'h8, 1, 0, 0, 0);  // 37
    add( 1, 0, 0, 4'b0111, 4'h8, 1, 0, 0, 0);  // 38
    add( 7, 0, 0, 4'b0111, 4'h8, 1, 0, 0, 0);  // 45
    add( 1, 0, 0, 4'b0111, 4'h0, 1, 0, 0, 0);  // 46: stage 3 released
    add( 1, 0, 0, 4'b0111, 4'h0, 1, 0, 0, 0);  // 47
    add( 1, 0, 0, 4'b1111, 4'h0, 0, 1, 0, 0);  // 48: ready3 -> DONE
    add( 4, 0, 0, 4'b1111, 4'h0, 0, 1, 0, 0);  // stays in DONE
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- single-stage instance, one-cycle hold ----------------
    @(negedge clk);
    step(2);
    check("deg.reset.rst_out", 32'(rst_out1), 32'h1);
    check("deg.reset.busy",    32'(busy1),    32'h1);
    check("deg.reset.done",    32'(done1),    32'h0);
    reset1 = 1'b0;
    step(1);
    check("deg.e1.rst_out", 32'(rst_out1), 32'h0);
    check("deg.e1.done",    32'(done1),    32'h0);
    check("deg.e1.busy",    32'(busy1),    32'h1);
    step(1);
    check("deg.e2.done",    32'(done1),    32'h1);
    check("deg.e2.busy",    32'(busy1),    32'h0);
    check("deg.e2.terr",    32'(terr1),    32'h0);
    check("deg.e2.estage",  32'(estage1),  32'h0);

    // ---------------- table: nominal, timeout, re-sequence ----------------
    add(2, 1, 0, 4'b0000, 4'hF, 1, 0, 0, 0);   // block reset
    add_nominal();

    add(1, 1, 0, 4'b0000, 4'hF, 1, 0, 0, 0);   // reset, then stage 2 never ready
    add(16, 0, 0, 4'b0000, 4'hE, 1, 0, 0, 0);  // 16
    add( 1, 0, 0, 4'b0000, 4'hE, 1, 0, 0, 0);  // 17
    add( 1, 0, 0, 4'b0001, 4'hE, 1, 0, 0, 0);  // 18
    add( 8, 0, 0, 4'b0001, 4'hC, 1, 0, 0, 0);  // 26
    add( 1, 0, 0, 4'b0001, 4'hC, 1, 0, 0, 0);  // 27
    add( 1, 0, 0, 4'b0011, 4'hC, 1, 0, 0, 0);  // 28
    add( 8, 0, 0, 4'b0011, 4'h8, 1, 0, 0, 0);  // 36: RELEASE(2)
    add(63, 0, 0, 4'b0011, 4'h8, 1, 0, 0, 0);  // 99: one short of timeout
    add( 1, 0, 0, 4'b0011, 4'h8, 1, 0, 1, 2);  // 100: timeout on stage 2
    add( 7, 0, 0, 4'b0011, 4'h8, 1, 0, 1, 2);  // 107
    add( 1, 0, 0, 4'b0011, 4'h0, 1, 0, 1, 2);  // 108: stage 3 released
    add( 1, 0, 0, 4'b0011, 4'h0, 1, 0, 1, 2);  // 109
    add( 1, 0, 0, 4'b1011, 4'h0, 0, 1, 1, 2);  // 110: DONE, error kept
    add( 3, 0, 0, 4'b1011, 4'h0, 0, 1, 1, 2);

    add(1, 0, 1, 4'b0000, 4'hF, 1, 0, 0, 0);   // sw_rst_req from DONE
    add_nominal();

    for (int i = 0; i < vecs.size(); i++) begin
      reset       = vecs[i].rst;
      sw_rst_req  = vecs[i].sw;
      stage_ready = vecs[i].ready;
      step(int'(vecs[i].cycles));
      check_out($sformatf("vec%0d", i), vecs[i].exp_rst, vecs[i].exp_busy,
                vecs[i].exp_done, vecs[i].exp_terr, vecs[i].exp_estage);
    end

    // ---------------- restart at the GAP terminal edge ----------------
    sw_rst_req = 1'b0;
    reset = 1'b1;  stage_ready = 4'b0000;
    step(1);
    reset = 1'b0;
    step(17);                          // edge 17, ready0 still low
    stage_ready = 4'b0001;
    step(9);                           // edge 26
    check_out("mid.rel1", 4'hC, 1, 0, 0, 0);
    step(1);                           // 27
    stage_ready = 4'b0011;
    step(8);                           // 28 ready1 -> GAP, through 35
    check_out("mid.gap1", 4'hC, 1, 0, 0, 0);
    sw_rst_req = 1'b1;                 // edge 36 is the GAP terminal edge
    step(1);
    check_out("mid.restart", 4'hF, 1, 0, 0, 0);
    sw_rst_req = 1'b0;  stage_ready = 4'b0000;
    step(15);
    check_out("mid.hold15", 4'hF, 1, 0, 0, 0);
    step(1);
    check_out("mid.rel0", 4'hE, 1, 0, 0, 0);

    // ---------------- stage 1 timeout, then reset in RELEASE(2) ----------------
    step(1);                           // 17
    stage_ready = 4'b0001;
    step(9);                           // 18 -> GAP, 26 stage 1 released
    check_out("rst.rel1", 4'hC, 1, 0, 0, 0);
    step(63);                          // 89
    check_out("rst.pre_tmo", 4'hC, 1, 0, 0, 0);
    step(1);                           // 90: stage 1 timed out
    check_out("rst.tmo1", 4'hC, 1, 0, 1, 1);
    step(8);                           // 98: stage 2 released
    check_out("rst.rel2", 4'h8, 1, 0, 1, 1);
    step(1);                           // 99
    reset = 1'b1;
    step(1);                           // 100
    check_out("rst.clear", 4'hF, 1, 0, 0, 0);
    reset = 1'b0;  stage_ready = 4'b0000;
    step(15);
    check_out("rst.hold15", 4'hF, 1, 0, 0, 0);
    step(1);
    check_out("rst.rel0", 4'hE, 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Drives ordered, stretched active-high resets to NUM_STAGES downstream domains.
- Each domain's own reset synchronizer returns a stage_ready indication once it has seen release.
- Holds all stage resets for HOLD_CYCLES, then releases stages 0..N-1 in order. Each release waits for stage_ready (or a timeout) and then a GAP_CYCLES spacing.
- Supports a software-requested re-sequence at any time.

Parameters:
- NUM_STAGES, 4, number of reset outputs; must be >= 1.
- HOLD_CYCLES, 16, cycles all rst_out stay asserted before stage 0 is released; must be >= 1.
- GAP_CYCLES, 8, cycles between stage i ready and stage i+1 release; must be >= 1.
- TIMEOUT_CYCLES, 64, maximum cycles to wait for stage_ready[i]; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high block reset
- sw_rst_req  input  1  request full re-sequence; sampled every edge
- stage_ready  input  NUM_STAGES  per-stage "reset released" acknowledge, already synchronous to clk
- rst_out  output  NUM_STAGES  per-stage active-high reset, registered
- seq_busy  output  1  sequence in progress
- seq_done  output  1  all stages released
- timeout_err  output  1  sticky: some stage timed out
- err_stage  output  max(1,$clog2(NUM_STAGES))  index of the most recent timed-out stage

Behaviour:
- One clock, clk. reset is synchronous and active-high, and has priority over everything.
- All outputs are registered.
- While reset=1, at each edge:
  - state=ASSERT, cnt=0, idx=0.
  - rst_out = all ones, seq_busy=1, seq_done=0, timeout_err=0, err_stage=0.
- sw_rst_req=1 in any state (reset low) has the same effect as reset, except it is a one-edge event.
  - sw_rst_req wins over simultaneous stage_ready or counter terminal events.
- Counter cnt width: clog2 of max(HOLD_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES). It is cleared on every state transition.
- ASSERT:
  - rst_out all ones; cnt increments.
  - When cnt==HOLD_CYCLES-1: go to RELEASE and clear rst_out[0] on the same edge.
  - Net effect: rst_out[0] falls at the HOLD_CYCLES-th edge after reset/sw_rst_req goes low.
- RELEASE (stage idx):
  - rst_out[idx] is low; cnt increments.
  - If stage_ready[idx]==1: go to GAP, or to DONE if idx==NUM_STAGES-1.
  - Else if cnt==TIMEOUT_CYCLES-1: set timeout_err<=1 and err_stage<=idx, then take the same transition as ready.
  - stage_ready bits for other stages are ignored.
- GAP:
  - cnt increments.
  - When cnt==GAP_CYCLES-1: idx<=idx+1, clear rst_out[idx+1] on the same edge, go to RELEASE.
- DONE:
  - seq_done=1, seq_busy=0, rst_out all zero. Remain here until reset or sw_rst_req.
- seq_busy=1 in ASSERT, RELEASE and GAP.
- seq_done and seq_busy change on the same edge as the state change.
- Released stages stay released until re-sequence; no stage is ever re-asserted individually.
- timeout_err and err_stage clear only on reset or sw_rst_req.
- No combinational path from any input to any output.

Decomposition:
- Package rst_seq_pkg holds:
  - typedef enum logic [1:0] {ASSERT, RELEASE, GAP, DONE} rst_seq_state_t
  - a localparam helper for counter width (max of the three cycle parameters, then clog2).
- Optional sub-module rst_seq_timer: clear/enable up-counter with terminal-count compare input.
- The FSM stays in reset_sequencer.

Test Plan:
All cases use defaults (N=4, HOLD=16, GAP=8, TIMEOUT=64) unless stated.
- Nominal: drop reset; bench raises stage_ready[i] 2 cycles after rst_out[i] falls -> rst_out=4'hF for 16 edges, then 4'hE, 4'hC, 4'h8, 4'h0 at 10-cycle spacing; seq_done=1 and seq_busy=0 on the edge that samples stage_ready[3]; timeout_err=0.
- Timeout: as nominal but stage_ready[2] held 0 -> after 64 cycles in RELEASE(2), timeout_err=1 and err_stage=2; rst_out[3] falls 8 cycles later; seq_done reaches 1.
- Re-sequence from DONE, after the timeout case: sw_rst_req pulse -> next edge rst_out=4'hF, seq_done=0, seq_busy=1, timeout_err=0; the nominal timeline repeats exactly.
- Mid-sequence restart: sw_rst_req in GAP after stage 1, coincident with stage_ready[1]=1 -> next edge rst_out=4'hF and state=ASSERT; the full 16-cycle hold is re-counted.
- Reset mid-operation: reset high for 1 cycle during RELEASE(2) -> rst_out=4'hF, err cleared; rst_out[0] falls 16 edges after reset drops.
- Degenerate: NUM_STAGES=1, HOLD=1, stage_ready tied 1 -> rst_out falls at the first edge after reset drops; seq_done rises on the next edge.
